multicycle_control: RTL and testbench

Main control finite state machine for the multicycle version of the MIPS-subset processor. Each instruction takes several clock cycles. Per state, the block decodes the 6-bit opcode held in the instruction register and drives every datapath enable and mux select. It produces the 2-bit ALUOp consumed by ALUControl. It stalls on a single-bit memory-ready handshake for instruction fetch, load and store.

---
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset processor: sequences each
// instruction over several cycles and drives every datapath enable and mux select.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       memto_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       done;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t cur_state;
    state_t next_state;
    ctrl_t  ctrl;
    logic   op_legal;
    logic   fetch_grant;

    // Moore control word for a state; the fetch-time PC/IR write is added later
    // because it depends on mem_ready in the same cycle.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            MEMWB: begin
                c.memto_reg = 1'b1;
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.ior_d     = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            ADDIWB: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.done          = 1'b1;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                c.done      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                   (opcode == OP_BEQ)   || (opcode == OP_J)  || (opcode == OP_ADDI);
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        next_state = FETCH;
        case (cur_state)
            FETCH:   next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDIEX;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:  next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   next_state = mem_ready ? MEMWB : MEMRD;
            MEMWR:   next_state = mem_ready ? FETCH : MEMWR;
            EXECUTE: next_state = ALUWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    // State, registered control word (decoded from the state being entered) and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= FETCH;
            ctrl       <= decode(FETCH);
            illegal_op <= 1'b0;
        end else begin
            cur_state <= next_state;
            ctrl      <= decode(next_state);
            if (cur_state == DECODE && !op_legal) begin
                illegal_op <= 1'b1;
            end
        end
    end

    // Write enables are masked by rst so an aborted instruction never commits.
    always_comb begin
        fetch_grant = (cur_state == FETCH) && mem_ready;
        PCWrite     = (ctrl.pc_write | fetch_grant) & ~rst;
        IRWrite     = fetch_grant & ~rst;
        PCWriteCond = ctrl.pc_write_cond & ~rst;
        MemRead     = ctrl.mem_read & ~rst;
        MemWrite    = ctrl.mem_write & ~rst;
        RegWrite    = ctrl.reg_write & ~rst;
        IorD        = ctrl.ior_d;
        MemtoReg    = ctrl.memto_reg;
        ALUSrcA     = ctrl.alu_src_a;
        RegDst      = ctrl.reg_dst;
        PCSource    = ctrl.pc_source;
        ALUSrcB     = ctrl.alu_src_b;
        ALUOp       = ctrl.alu_op;
        state       = cur_state;
        instr_done  = ctrl.done | ((cur_state == MEMWR) && mem_ready) |
                      ((cur_state == DECODE) && !op_legal);
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    typedef struct {
        int         step;
        logic [3:0] st;
        logic [15:0] ctl;
        logic       done;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    localparam logic [5:0] R_OP  = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] JMP   = 6'b000010;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] BAD   = 6'b111111;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
    // ALUSrcA RegWrite RegDst PCSource[2] ALUSrcB[2] ALUOp[2], taken from the state table.
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic r);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rd;
        logic [1:0] pcs, srcb, aop;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rd} = '0;
        pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
        case (st)
            4'd0:  begin mrd = 1; srcb = 2'b01; pcw = mr; irw = mr; end
            4'd1:  srcb = 2'b11;
            4'd2, 4'd10: begin srca = 1; srcb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin srca = 1; aop = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd9:  begin pcw = 1; pcs = 2'b10; end
            4'd11: rw = 1;
            default: ;
        endcase
        if (r) begin
            pcw = 0; pcwc = 0; irw = 0; mrd = 0; mwr = 0; rw = 0;
        end
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rd, pcs, srcb, aop};
    endfunction

    task automatic check_output(input string name, input int step, input logic [15:0] act,
                                input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %h, expected %h", name, step, act, req);
        end
    endtask

    // Drives one cycle of inputs just after the edge and, if requested, queues its expectation.
    task automatic apply_stimulus(input logic r, input logic [5:0] op, input logic mr,
                                  input logic chk, input logic [3:0] st, input logic dn,
                                  input logic il);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        opcode = op;
        mem_ready = mr;
        step_no++;
        if (chk) begin
            e.step = step_no;
            e.st   = st;
            e.ctl  = exp_ctrl(st, mr, r);
            e.done = dn;
            e.ill  = il;
            sb.push_back(e);
        end
    endtask

    // Monitor: compares whatever expectation is pending for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output("state", e.step, {12'd0, state}, {12'd0, e.st});
            check_output("ctrl", e.step,
                {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp}, e.ctl);
            check_output("instr_done", e.step, {15'd0, instr_done}, {15'd0, e.done});
            check_output("illegal_op", e.step, {15'd0, illegal_op}, {15'd0, e.ill});
        end
    end

    initial begin
        // Reset: first cycle state unknown, second cycle state=FETCH with writes masked
        apply_stimulus(1, R_OP, 1, 0, 0, 0, 0);
        apply_stimulus(1, R_OP, 1, 1, 0, 0, 0);
        // R-type: 0,1,6,7
        apply_stimulus(0, R_OP, 1, 1, 0, 0, 0);
        apply_stimulus(0, R_OP, 1, 1, 1, 0, 0);
        apply_stimulus(0, R_OP, 1, 1, 6, 0, 0);
        apply_stimulus(0, R_OP, 1, 1, 7, 1, 0);
        // lw with two MEMRD stalls: 0,1,2,3,3,3,4
        apply_stimulus(0, LW, 1, 1, 0, 0, 0);
        apply_stimulus(0, LW, 1, 1, 1, 0, 0);
        apply_stimulus(0, LW, 1, 1, 2, 0, 0);
        apply_stimulus(0, LW, 0, 1, 3, 0, 0);
        apply_stimulus(0, LW, 0, 1, 3, 0, 0);
        apply_stimulus(0, LW, 1, 1, 3, 0, 0);
        apply_stimulus(0, LW, 1, 1, 4, 1, 0);
        // sw with one MEMWR stall: done only when memory completes
        apply_stimulus(0, SW, 1, 1, 0, 0, 0);
        apply_stimulus(0, SW, 1, 1, 1, 0, 0);
        apply_stimulus(0, SW, 1, 1, 2, 0, 0);
        apply_stimulus(0, SW, 0, 1, 5, 0, 0);
        apply_stimulus(0, SW, 1, 1, 5, 1, 0);
        // beq then j
        apply_stimulus(0, BEQ, 1, 1, 0, 0, 0);
        apply_stimulus(0, BEQ, 1, 1, 1, 0, 0);
        apply_stimulus(0, BEQ, 1, 1, 8, 1, 0);
        apply_stimulus(0, JMP, 1, 1, 0, 0, 0);
        apply_stimulus(0, JMP, 1, 1, 1, 0, 0);
        apply_stimulus(0, JMP, 1, 1, 9, 1, 0);
        // Fetch stall for three cycles, then an R-type completes
        apply_stimulus(0, R_OP, 0, 1, 0, 0, 0);
        apply_stimulus(0, R_OP, 0, 1, 0, 0, 0);
        apply_stimulus(0, R_OP, 0, 1, 0, 0, 0);
        apply_stimulus(0, R_OP, 1, 1, 0, 0, 0);
        apply_stimulus(0, R_OP, 1, 1, 1, 0, 0);
        apply_stimulus(0, R_OP, 1, 1, 6, 0, 0);
        apply_stimulus(0, R_OP, 1, 1, 7, 1, 0);
        // Illegal opcode: done in DECODE, sticky flag afterwards
        apply_stimulus(0, BAD, 1, 1, 0, 0, 0);
        apply_stimulus(0, BAD, 1, 1, 1, 1, 0);
        apply_stimulus(0, ADDI, 1, 1, 0, 0, 1);
        apply_stimulus(0, ADDI, 1, 1, 1, 0, 1);
        apply_stimulus(0, ADDI, 1, 1, 10, 0, 1);
        // Reset lands in ADDIWB: RegWrite suppressed, then flag cleared
        apply_stimulus(1, ADDI, 1, 1, 11, 1, 1);
        apply_stimulus(0, ADDI, 1, 1, 0, 0, 0);
        apply_stimulus(0, ADDI, 1, 1, 1, 0, 0);
        apply_stimulus(0, ADDI, 1, 1, 10, 0, 0);
        apply_stimulus(0, ADDI, 1, 1, 11, 1, 0);
        apply_stimulus(0, ADDI, 1, 1, 0, 0, 0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
